// File: rtl/maxpool_2x2.sv
// rtl/maxpool_2x2.sv - 2x2 stride-2 signed max pooling over a raster convolution stream
module maxpool_2x2 #(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_SIZE  = 28,
  parameter int KERNEL_SIZE = 5
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         conv_valid,
  input  logic signed [DATA_WIDTH-1:0] conv_data,
  output logic                         pool_valid,
  output logic signed [DATA_WIDTH-1:0] pool_data,
  output logic                         pool_last
);

  localparam int CONV_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int HALF      = CONV_SIZE / 2;
  localparam int CW        = (CONV_SIZE > 1) ? $clog2(CONV_SIZE) : 1;
  localparam int AW        = (HALF > 1) ? $clog2(HALF) : 1;
  // Last odd index that still closes a complete window; with odd CONV_SIZE
  // the trailing column/row sits beyond it and never produces a result.
  localparam int LAST_ODD  = 2 * HALF - 1;

  logic [CW-1:0]                col;
  logic [CW-1:0]                row;
  logic signed [DATA_WIDTH-1:0] hold;
  logic signed [DATA_WIDTH-1:0] linebuf [HALF];

  logic [AW-1:0]                lb_idx;
  logic signed [DATA_WIDTH-1:0] hmax;
  logic signed [DATA_WIDTH-1:0] lb_rd;
  logic signed [DATA_WIDTH-1:0] pool_max;
  logic                         col_end;
  logic                         row_end;
  logic                         emit;
  logic                         last_win;

  // Horizontal pair max, vertical merge with the buffered upper row, and position decode
  always_comb begin
    lb_idx   = AW'(col >> 1);
    hmax     = (conv_data > hold) ? conv_data : hold;
    lb_rd    = linebuf[lb_idx];
    pool_max = (lb_rd > hmax) ? lb_rd : hmax;
    col_end  = (col == CW'(CONV_SIZE - 1));
    row_end  = (row == CW'(CONV_SIZE - 1));
    emit     = conv_valid && row[0] && col[0];
    last_win = (row == CW'(LAST_ODD)) && (col == CW'(LAST_ODD));
  end

  // Raster position counters and even-column hold register, advanced only on accepted samples
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col  <= '0;
      row  <= '0;
      hold <= '0;
    end else if (conv_valid) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
      if (!col[0]) hold <= conv_data;
    end
  end

  // Even-row pair maxima parked for the odd row below; every entry is rewritten before use
  always_ff @(posedge clk) begin
    if (conv_valid && !row[0] && col[0]) linebuf[lb_idx] <= hmax;
  end

  // Registered result: one-cycle strobe, data held between strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pool_valid <= 1'b0;
      pool_data  <= '0;
      pool_last  <= 1'b0;
    end else begin
      pool_valid <= emit;
      pool_last  <= emit && last_win;
      if (emit) pool_data <= pool_max;
    end
  end

endmodule

// File: tb/tb_maxpool_2x2.sv
// tb/tb_maxpool_2x2.sv - randomized and directed checks of maxpool_2x2 against a frame-level model
module tb_maxpool_2x2;

  localparam int DW = 16;
  localparam int CS = 24;
  localparam int H  = CS / 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 conv_valid;
  logic signed [DW-1:0] conv_data;
  logic                 pool_valid;
  logic signed [DW-1:0] pool_data;
  logic                 pool_last;

  int total = 0;
  int bad   = 0;

  logic signed [DW-1:0] img [CS][CS];
  logic signed [DW-1:0] exp_pd;
  logic signed [DW-1:0] got_q [$];
  int                   pv_count;
  int                   last_count;

  maxpool_2x2 #(.DATA_WIDTH(DW), .IMAGE_SIZE(28), .KERNEL_SIZE(5)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .conv_valid (conv_valid),
    .conv_data  (conv_data),
    .pool_valid (pool_valid),
    .pool_data  (pool_data),
    .pool_last  (pool_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // One clock: drive inputs, let the edge pass, then compare outputs against the model.
  task automatic step(input logic v, input logic signed [DW-1:0] d,
                      input logic ev, input logic signed [DW-1:0] ed, input logic el);
    conv_valid = v;
    conv_data  = d;
    @(posedge clk);
    #1;
    chk("pool_valid", {31'd0, pool_valid}, {31'd0, ev});
    chk("pool_data", pool_data, ed);
    chk("pool_last", {31'd0, pool_last}, {31'd0, el});
    if (pool_valid) begin
      pv_count++;
      got_q.push_back(pool_data);
    end
    if (pool_last) last_count++;
  endtask

  // Stream img[][] in raster order; gap idle cycles after each row; stop early at sample stop_at.
  task automatic run_frame(input int gap, input int stop_at);
    int idx = 0;
    logic ev;
    logic el;
    for (int r = 0; r < CS; r++) begin
      for (int c = 0; c < CS; c++) begin
        if (idx == stop_at) return;
        idx++;
        ev = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * H) && (c < 2 * H);
        el = ev && (r == 2 * H - 1) && (c == 2 * H - 1);
        if (ev)
          exp_pd = smax(smax(img[r-1][c-1], img[r-1][c]), smax(img[r][c-1], img[r][c]));
        step(1'b1, img[r][c], ev, exp_pd, el);
      end
      for (int g = 0; g < gap; g++) step(1'b0, DW'($urandom), 1'b0, exp_pd, 1'b0);
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < CS; r++)
      for (int c = 0; c < CS; c++) img[r][c] = DW'(r * CS + c);
  endtask

  task automatic fill_rand();
    int k;
    for (int r = 0; r < CS; r++)
      for (int c = 0; c < CS; c++) begin
        k = $urandom_range(0, 7);
        if (k == 0)      img[r][c] = 16'sh8000;
        else if (k == 1) img[r][c] = 16'sh7fff;
        else             img[r][c] = DW'($urandom);
      end
  endtask

  task automatic clear_stats();
    pv_count   = 0;
    last_count = 0;
    got_q.delete();
  endtask

  initial begin
    rstn       = 1'b0;
    conv_valid = 1'b0;
    conv_data  = '0;
    exp_pd     = '0;
    clear_stats();
    #12;
    chk("reset_valid", {31'd0, pool_valid}, 32'd0);
    chk("reset_data", pool_data, 32'd0);
    chk("reset_last", {31'd0, pool_last}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Ramp, continuous
    fill_ramp();
    clear_stats();
    run_frame(0, -1);
    chk("ramp_count", pv_count, 144);
    chk("ramp_last_count", last_count, 1);
    chk("ramp_first", got_q[0], 25);
    chk("ramp_second", got_q[1], 27);
    chk("ramp_final", got_q[143], 575);

    // Ramp with row turnaround gaps
    clear_stats();
    run_frame(4, -1);
    chk("gap_count", pv_count, 144);
    chk("gap_final", got_q[143], 575);

    // Signed extremes in the first two windows
    fill_rand();
    img[0][0] = 16'sh8000; img[0][1] = -16'sd5;
    img[1][0] = -16'sd1;   img[1][1] = -16'sd7;
    img[0][2] = 16'sh8000; img[0][3] = 16'sh8000;
    img[1][2] = 16'sh8000; img[1][3] = 16'sh8000;
    clear_stats();
    run_frame(0, -1);
    chk("signed_win0", got_q[0], 32'hffffffff);
    chk("signed_win1", got_q[1], 32'hffff8000);

    // Back-to-back random frames with no idle in between
    clear_stats();
    fill_rand();
    run_frame(0, -1);
    fill_rand();
    run_frame(0, -1);
    chk("b2b_count", pv_count, 288);
    chk("b2b_last_count", last_count, 2);

    // Mid-frame asynchronous reset, then a fresh frame from row 0, col 0
    fill_rand();
    run_frame(0, 100);
    conv_valid = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    exp_pd = '0;
    chk("midrst_valid", {31'd0, pool_valid}, 32'd0);
    chk("midrst_data", pool_data, 32'd0);
    chk("midrst_last", {31'd0, pool_last}, 32'd0);
    @(posedge clk);
    #3;
    chk("midrst_hold_data", pool_data, 32'd0);
    conv_valid = 1'b0;
    rstn = 1'b1;
    fill_rand();
    clear_stats();
    run_frame(2, -1);
    chk("postrst_count", pv_count, 144);
    chk("postrst_last_count", last_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
